eq_band_coef_loader: RTL

Sequences coefficient loading into the equalizer's per-band filter stages. Accepts one (band, coefficient) write at a time over a valid/ready handshake, then shifts the coefficient MSB-first onto a shared serial line. It steers that line to the addressed band with a one-hot enable, then pulses that band's latch strobe. Sits between the control/host interface and the band filter bank, and drives the same one-of-N routing the bank's 1-to-8 data demux uses.

---
 rtl/eq_band_coef_loader.sv | 89 ++++++++
 1 files changed

// File: rtl/eq_band_coef_loader.sv
// eq_band_coef_loader: serially loads one coefficient MSB-first into an addressed band, then strobes its latch.
// Optional broadcast to all bands is enabled by defining EQ_CFG_BCAST_EN.
module eq_band_coef_loader #(
  parameter int NUM_BANDS = 8,
  parameter int COEF_W    = 16,
  parameter int SEL_W     = 3
) (
  input  logic              clk,
  input  logic              rst,
`ifdef EQ_CFG_BCAST_EN
  input  logic              cfg_bcast,
`endif
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [SEL_W-1:0]  cfg_band,
  input  logic [COEF_W-1:0] cfg_coef,
  output logic [SEL_W-1:0]  band_sel,
  output logic              ser_data,
  output logic [7:0]        ser_en,
  output logic [7:0]        band_latch,
  output logic              busy,
  output logic              err_band
);
  localparam int CNT_W = $clog2(COEF_W);
  localparam logic [7:0] MASK = 8'((9'd1 << NUM_BANDS) - 9'd1);
  typedef enum logic [1:0] {IDLE, SHIFT, LATCH} state_t;
  state_t              state_q;
  logic [SEL_W-1:0]    band_q;
  logic [COEF_W-1:0]   shreg_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [7:0]          en_q, latch_q;
  logic                err_q;
  logic                bcast, bad;
  logic [7:0]          tgt;
`ifdef EQ_CFG_BCAST_EN
  assign bcast = cfg_bcast;
`else
  assign bcast = 1'b0;
`endif
  assign bad = !bcast && ({1'b0, cfg_band} >= (SEL_W+1)'(NUM_BANDS));
  assign tgt = bcast ? MASK : 8'b1 << cfg_band;
  // en_q carries the target mask through SHIFT so LATCH strobes the same bands
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      band_q  <= '0;
      shreg_q <= '0;
      cnt_q   <= '0;
      en_q    <= '0;
      latch_q <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          err_q <= cfg_valid && bad;
          if (cfg_valid && !bad) begin
            state_q <= SHIFT;
            band_q  <= bcast ? '0 : cfg_band;
            shreg_q <= cfg_coef;
            cnt_q   <= CNT_W'(COEF_W - 1);
            en_q    <= tgt;
          end
        end
        SHIFT: begin
          shreg_q <= shreg_q << 1;
          if (cnt_q == '0) begin
            state_q <= LATCH;
            latch_q <= en_q;
            en_q    <= '0;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        LATCH: begin
          state_q <= IDLE;
          latch_q <= '0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign cfg_ready  = state_q == IDLE;
  assign busy       = state_q != IDLE;
  assign ser_data   = (state_q == SHIFT) && shreg_q[COEF_W-1];
  assign ser_en     = en_q;
  assign band_latch = latch_q;
  assign band_sel   = band_q;
  assign err_band   = err_q;
endmodule
